// File: rtl/core_pkg.sv
// Shared types and defaults for the multi-cycle core sequencer.
// Holds the sequencer state encoding, the decoder memory-operation codes,
// the fault codes reported on fault_o, and the default reset PC / watchdog
// limit used by core_sequencer and seq_watchdog.
package core_pkg;

  // Sequencer states; one instruction is in flight at a time
  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXECUTE    = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WRITEBACK  = 3'd5,
    HALT       = 3'd6
  } seq_state_e;

  // Memory operation as reported by the decoder
  typedef enum logic [1:0] {
    MEM_NONE    = 2'd0,
    MEM_LOAD    = 2'd1,
    MEM_STORE   = 2'd2,
    MEM_ILLEGAL = 2'd3
  } mem_op_e;

  // Reason the core halted
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_ILLEGAL  = 2'd1,
    FAULT_TIMEOUT  = 2'd2,
    FAULT_MISALIGN = 2'd3
  } fault_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 255;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // States in which the core waits on a memory handshake and the watchdog runs
  function automatic logic isWaitState(input seq_state_e s);
    return (s == FETCH_REQ) || (s == FETCH_WAIT) || (s == MEM_REQ) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/core_sequencer_watchdog.sv
// seq_watchdog: 8-bit cycle counter guarding the handshake-wait states.
// Ports:
//   clk_i      clock
//   rstn_i     synchronous active-low reset
//   clear_i    sequencer changes state this cycle; counter restarts from 0
//   enable_i   sequencer is in a wait state; counter advances
//   expired_o  count reaches TIMEOUT_CYC at the coming edge
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [8:0] countInc;

  // One extra bit so the compare against the limit cannot alias on wrap
  assign countInc = {1'b0, count_q} + 9'd1;

  // expired_o depends only on the current count and the enable, never on
  // clear_i, because clear_i is derived from the next state that this
  // output itself helps select.
  assign expired_o = enable_i && (countInc == 9'(TIMEOUT_CYC));

  // Next count: a state change restarts the count, waiting advances it,
  // otherwise (EXECUTE, WRITEBACK, HALT) it holds.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = countInc[7:0];
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control sequencer for the 32-bit core.
// Fetches one instruction, holds it in the instruction register for the
// decoder/ALU, optionally performs one data access, then writes back and
// advances the PC. Any fault parks the core in HALT until reset.
// Ports:
//   clk_i, rstn_i                      clock, synchronous active-low reset
//   imem_valid_o/ready_i/addr_o        fetch request handshake
//   imem_rvalid_i/rdata_i              fetch response
//   instr_o                            instruction register to decoder
//   dec_wr_en_i, dec_mem_op_i          decoder results
//   alu_result_i, rs2_data_i           data address / store data
//   pc_redirect_i, pc_target_i         branch/jump control
//   dmem_valid_o/ready_i/we_o/addr_o/wdata_o   data request
//   dmem_rvalid_i/rdata_i              load response / store ack
//   ld_data_o                          latched load data
//   rf_wr_en_o                         register-file write strobe
//   pc_o, instret_o                    PC and retired-instruction count
//   halt_o, fault_o                    halt flag and fault reason
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_valid_o,
  input  logic        imem_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  input  logic        dec_wr_en_i,
  input  logic [1:0]  dec_mem_op_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic        pc_redirect_i,
  input  logic [31:0] pc_target_i,
  output logic        dmem_valid_o,
  input  logic        dmem_ready_i,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] ld_data_o,
  output logic        rf_wr_en_o,
  output logic [31:0] pc_o,
  output logic [31:0] instret_o,
  output logic        halt_o,
  output logic [1:0]  fault_o
);

  seq_state_e  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] ldData_q,    ldData_d;
  logic [31:0] dmemAddr_q,  dmemAddr_d;
  logic [31:0] dmemWdata_q, dmemWdata_d;
  mem_op_e     memOp_q,     memOp_d;
  logic [31:0] instret_q,   instret_d;
  fault_e      fault_q,     fault_d;

  logic wdExpired;
  logic badTarget;

  // A redirect to a non-word-aligned target is a fault, not a jump
  assign badTarget = pc_redirect_i && (pc_target_i[1:0] != 2'b00);

  seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clear_i  (state_d != state_q),
    .enable_i (isWaitState(state_q)),
    .expired_o(wdExpired)
  );

  // Moore outputs decoded from the current state and latched registers.
  // The register-file strobe is suppressed when the writeback is about to
  // fault on a misaligned redirect.
  assign imem_valid_o = (state_q == FETCH_REQ);
  assign imem_addr_o  = pc_q;
  assign dmem_valid_o = (state_q == MEM_REQ);
  assign dmem_we_o    = (memOp_q == MEM_STORE);
  assign dmem_addr_o  = dmemAddr_q;
  assign dmem_wdata_o = dmemWdata_q;
  assign instr_o      = instr_q;
  assign ld_data_o    = ldData_q;
  assign rf_wr_en_o   = (state_q == WRITEBACK) && dec_wr_en_i && !badTarget;
  assign pc_o         = pc_q;
  assign instret_o    = instret_q;
  assign halt_o       = (state_q == HALT);
  assign fault_o      = fault_q;

  // Next-state logic. In every wait state a completing handshake is checked
  // before the watchdog, so a response arriving on the expiry cycle still
  // goes through. HALT is only entered from a running state, so the first
  // fault recorded is the one that stays visible.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ldData_d    = ldData_q;
    dmemAddr_d  = dmemAddr_q;
    dmemWdata_d = dmemWdata_q;
    memOp_d     = memOp_q;
    instret_d   = instret_q;
    fault_d     = fault_q;

    case (state_q)
      FETCH_REQ: begin
        if (imem_ready_i) begin
          state_d = FETCH_WAIT;
        end else if (wdExpired) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = EXECUTE;
        end else if (wdExpired) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      EXECUTE: begin
        case (mem_op_e'(dec_mem_op_i))
          MEM_ILLEGAL: begin
            state_d = HALT;
            fault_d = FAULT_ILLEGAL;
          end
          MEM_LOAD, MEM_STORE: begin
            dmemAddr_d  = alu_result_i;
            dmemWdata_d = rs2_data_i;
            memOp_d     = mem_op_e'(dec_mem_op_i);
            state_d     = MEM_REQ;
          end
          default: begin
            memOp_d = MEM_NONE;
            state_d = WRITEBACK;
          end
        endcase
      end

      MEM_REQ: begin
        if (dmem_ready_i) begin
          state_d = MEM_WAIT;
        end else if (wdExpired) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          if (memOp_q == MEM_LOAD) begin
            ldData_d = dmem_rdata_i;
          end
          state_d = WRITEBACK;
        end else if (wdExpired) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end

      WRITEBACK: begin
        if (badTarget) begin
          state_d = HALT;
          fault_d = FAULT_MISALIGN;
        end else begin
          pc_d      = pc_redirect_i ? pc_target_i : (pc_q + PC_STEP);
          instret_d = instret_q + 32'd1;
          state_d   = FETCH_REQ;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // State and datapath registers. Reset abandons whatever transaction was
  // in flight; a late response then lands in FETCH_REQ and is ignored.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= FETCH_REQ;
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      ldData_q    <= 32'd0;
      dmemAddr_q  <= 32'd0;
      dmemWdata_q <= 32'd0;
      memOp_q     <= MEM_NONE;
      instret_q   <= 32'd0;
      fault_q     <= FAULT_NONE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ldData_q    <= ldData_d;
      dmemAddr_q  <= dmemAddr_d;
      dmemWdata_q <= dmemWdata_d;
      memOp_q     <= memOp_d;
      instret_q   <= instret_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. A tiny decoder is modelled from
// instr_o bits: [1:0] mem op, [2] writes rd, [3] redirect. Data-side values
// (ALU result, store data, target) come from per-instruction bench variables.
`timescale 1ns/1ps
module tb_core_sequencer;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_valid, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, instr_o;
  logic        dec_wr_en, pc_redirect;
  logic [1:0]  dec_mem_op;
  logic [31:0] alu_result, rs2_data, pc_target;
  logic        dmem_valid, dmem_ready, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ld_data;
  logic        rf_wr_en, halt;
  logic [31:0] pc, instret;
  logic [1:0]  fault;

  logic [31:0] curAlu, curRs2, curTarget;

  always #5 clk = ~clk;

  assign dec_mem_op  = instr_o[1:0];
  assign dec_wr_en   = instr_o[2];
  assign pc_redirect = instr_o[3];
  assign alu_result  = curAlu;
  assign rs2_data    = curRs2;
  assign pc_target   = curTarget;

  core_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .imem_valid_o (imem_valid),
    .imem_ready_i (imem_ready),
    .imem_addr_o  (imem_addr),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr_o),
    .dec_wr_en_i  (dec_wr_en),
    .dec_mem_op_i (dec_mem_op),
    .alu_result_i (alu_result),
    .rs2_data_i   (rs2_data),
    .pc_redirect_i(pc_redirect),
    .pc_target_i  (pc_target),
    .dmem_valid_o (dmem_valid),
    .dmem_ready_i (dmem_ready),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .ld_data_o    (ld_data),
    .rf_wr_en_o   (rf_wr_en),
    .pc_o         (pc),
    .instret_o    (instret),
    .halt_o       (halt),
    .fault_o      (fault)
  );

  int total = 0;
  int bad   = 0;

  // Architectural reference state
  logic [31:0] mPc, mInstret, mLd;
  logic        mHalted;
  logic [1:0]  mFault;
  int          mRf;
  int          rfBase;

  // Register-file strobe monitor, sampled on the falling edge
  int tick    = 0;
  int rfCount = 0;
  int pulseTicks[$];

  always @(negedge clk) begin
    tick++;
    if (rf_wr_en) begin
      rfCount++;
      pulseTicks.push_back(tick);
    end
  end

  // Hard time limit so a stuck run still ends
  initial begin
    #1000000;
    $display("[TB] FAIL simTimeLimit: got timeout expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    rstn        = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    @(negedge clk);
    rstn     = 1'b1;
    mPc      = 32'h0;
    mInstret = 32'd0;
    mLd      = 32'd0;
    mHalted  = 1'b0;
    mFault   = 2'd0;
    mRf      = 0;
    rfBase   = rfCount;
  endtask

  // Runs one instruction through fetch / optional data access / writeback,
  // checking handshakes on the way and architectural state at the end.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [31:0] target,
                               input logic [31:0] ldVal, input int rdyDly, input int rspDly,
                               input int dRdyDly, input int dRspDly);
    logic [1:0] op;
    logic       wr, redir, badTarget, expRf;
    int         budget, validTicks;
    op        = instr[1:0];
    wr        = instr[2];
    redir     = instr[3];
    badTarget = redir && (target[1:0] != 2'b00);
    expRf     = wr && !badTarget;
    curAlu    = alu;
    curRs2    = rs2;
    curTarget = target;

    budget = 0;
    while (!imem_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("fetchValid", 32'(imem_valid), 32'd1);
    if (!imem_valid) return;

    validTicks = 0;
    for (int k = 0; k < rdyDly; k++) begin
      validTicks += int'(imem_valid);
      @(negedge clk);
    end
    checkOutput("fetchAddr", imem_addr, mPc);
    validTicks += int'(imem_valid);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    checkOutput("fetchHeld", 32'(validTicks), 32'(rdyDly + 1));
    checkOutput("fetchDrop", 32'(imem_valid), 32'd0);

    repeat (rspDly) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    checkOutput("instrReg", instr_o, instr);

    if (op == 2'd3) begin
      @(negedge clk);
      mHalted = 1'b1;
      mFault  = 2'd1;
    end else begin
      if (op != 2'd0) begin
        @(negedge clk);
        checkOutput("dmemValid", 32'(dmem_valid), 32'd1);
        checkOutput("dmemAddr", dmem_addr, alu);
        checkOutput("dmemWe", 32'(dmem_we), 32'(op == 2'd2));
        if (op == 2'd2) checkOutput("dmemWdata", dmem_wdata, rs2);
        repeat (dRdyDly) @(negedge clk);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        checkOutput("dmemDrop", 32'(dmem_valid), 32'd0);
        repeat (dRspDly) @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = ldVal;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom();
        if (op == 2'd1) mLd = ldVal;
      end else begin
        @(negedge clk);
      end
      checkOutput("rfWrEn", 32'(rf_wr_en), 32'(expRf));
      checkOutput("ldData", ld_data, mLd);
      @(negedge clk);
      if (badTarget) begin
        mHalted = 1'b1;
        mFault  = 2'd3;
      end else begin
        mInstret = mInstret + 32'd1;
        mPc      = redir ? target : (mPc + 32'd4);
        mRf      = mRf + int'(expRf);
      end
    end

    checkOutput("halt", 32'(halt), 32'(mHalted));
    checkOutput("fault", 32'(fault), 32'(mFault));
    checkOutput("pc", pc, mPc);
    checkOutput("instret", instret, mInstret);
    checkOutput("imemValid", 32'(imem_valid), 32'(!mHalted));
  endtask

  initial begin
    int pBase;
    int waitTicks;
    curAlu    = 32'd0;
    curRs2    = 32'd0;
    curTarget = 32'd0;

    // Reset state
    resetDut();
    $display("[TB] reset values");
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstInstr", instr_o, 32'h0);
    checkOutput("rstLd", ld_data, 32'h0);
    checkOutput("rstDAddr", dmem_addr, 32'h0);
    checkOutput("rstDWdata", dmem_wdata, 32'h0);
    checkOutput("rstInstret", instret, 32'h0);
    checkOutput("rstHalt", 32'(halt), 32'd0);
    checkOutput("rstFault", 32'(fault), 32'd0);
    checkOutput("rstIValid", 32'(imem_valid), 32'd1);
    checkOutput("rstDValid", 32'(dmem_valid), 32'd0);
    checkOutput("rstDWe", 32'(dmem_we), 32'd0);
    checkOutput("rstRf", 32'(rf_wr_en), 32'd0);

    // Three zero-wait ALU ops then a zero-wait load: 4, 4, 6 cycle spacing
    $display("[TB] zero-wait ALU and load latency");
    pBase = pulseTicks.size();
    applyStimulus(32'h1230_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(32'h4560_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(32'h7890_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    checkOutput("pcAfter3", pc, 32'hC);
    checkOutput("instretAfter3", instret, 32'd3);
    applyStimulus(32'h0000_0005, 32'h0000_0040, 32'h0, 32'h0, 32'h1111_2222, 0, 0, 0, 0);
    checkOutput("pulseCount", 32'(pulseTicks.size() - pBase), 32'd4);
    if (pulseTicks.size() - pBase >= 4) begin
      checkOutput("gapAlu1", 32'(pulseTicks[pBase + 1] - pulseTicks[pBase]), 32'd4);
      checkOutput("gapAlu2", 32'(pulseTicks[pBase + 2] - pulseTicks[pBase + 1]), 32'd4);
      checkOutput("gapLoad", 32'(pulseTicks[pBase + 3] - pulseTicks[pBase + 2]), 32'd6);
    end

    // Fetch stalled 5 cycles, then a slow load and a store
    $display("[TB] stalled fetch, load, store");
    applyStimulus(32'h0000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 5, 0, 0, 0);
    applyStimulus(32'h0000_0005, 32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 3);
    checkOutput("ldDeadBeef", ld_data, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0002, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 32'h5555_AAAA, 0, 0, 1, 1);
    checkOutput("rfTotal1", 32'(rfCount - rfBase), 32'(mRf));

    // Aligned redirect, then misaligned redirect faults
    $display("[TB] redirects");
    applyStimulus(32'h0000_000C, 32'h0, 32'h0, 32'h0000_0100, 32'h0, 0, 0, 0, 0);
    checkOutput("pcRedirect", pc, 32'h0000_0100);
    applyStimulus(32'h0000_000C, 32'h0, 32'h0, 32'h0000_0102, 32'h0, 0, 0, 0, 0);
    checkOutput("misalignPc", pc, 32'h0000_0100);
    checkOutput("misalignFault", 32'(fault), 32'd3);
    checkOutput("rfTotal2", 32'(rfCount - rfBase), 32'(mRf));

    // PC wrap at the top of the address space
    $display("[TB] pc wrap");
    resetDut();
    applyStimulus(32'h0000_0008, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0);
    applyStimulus(32'h0000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    checkOutput("pcWrap", pc, 32'h0);

    // Illegal memory op
    $display("[TB] illegal op");
    resetDut();
    applyStimulus(32'h0000_0003, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0);
    checkOutput("illegalFault", 32'(fault), 32'd1);

    // Fetch never accepted: watchdog halts, late response ignored
    $display("[TB] fetch timeout");
    resetDut();
    waitTicks = 0;
    while (!halt && waitTicks < 30) begin
      @(negedge clk);
      waitTicks++;
    end
    checkOutput("timeoutCycles", 32'(waitTicks), 32'(TIMEOUT));
    checkOutput("timeoutFault", 32'(fault), 32'd2);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("timeoutInstr", instr_o, 32'h0);
    checkOutput("timeoutHold", 32'(halt), 32'd1);
    checkOutput("timeoutIValid", 32'(imem_valid), 32'd0);

    // Reset while a load waits for its response
    $display("[TB] reset during MEM_WAIT");
    resetDut();
    applyStimulus(32'h0000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    curAlu     = 32'h0000_0040;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0005;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("abortDValid", 32'(dmem_valid), 32'd1);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    resetDut();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BAD_0BAD;
    checkOutput("abortPc", pc, 32'h0);
    checkOutput("abortInstr", instr_o, 32'h0);
    checkOutput("abortInstret", instret, 32'h0);
    checkOutput("abortDAddr", dmem_addr, 32'h0);
    checkOutput("abortIValid", 32'(imem_valid), 32'd1);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("abortLd", ld_data, 32'h0);
    checkOutput("abortHalt", 32'(halt), 32'd0);
    applyStimulus(32'h0000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Randomized instruction stream with random handshake delays
    $display("[TB] random stream");
    resetDut();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r, tgt, ins;
      logic [1:0]  op;
      logic        wr, redir;
      r     = $urandom();
      op    = 2'($urandom_range(0, 2));
      wr    = (op != 2'd2) && r[2];
      redir = ($urandom_range(0, 3) == 0);
      tgt   = $urandom();
      tgt[1:0] = 2'b00;
      ins   = {r[31:4], redir, wr, op};
      applyStimulus(ins, $urandom(), $urandom(), tgt, $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (2) @(negedge clk);
    checkOutput("rfTotalRand", 32'(rfCount - rfBase), 32'(mRf));
    checkOutput("instretRand", instret, 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
